systolic_os_array: RTL and testbench
====================================

# systolic_os_array

Parametrised output-stationary systolic matrix-multiply engine, the next generation of the `systolic` block. It computes C = A·B for an ARRAY_SIZE×ARRAY_SIZE tile over a runtime-selectable inner dimension K. Operand skewing is done internally, and it supports signed or unsigned operands and accumulate-or-clear. It sits between the SRAM operand fetch logic and the post-processing/writeback stage, with valid/ready handshakes on both sides.

## Interface
- ARRAY_SIZE, 8: tile dimension N; the array has N×N PEs.
- DATA_WIDTH, 8: operand width.
- ACC_WIDTH, 21: accumulator width (2·DATA_WIDTH+5).
- K_WIDTH, 9: width of k_len.
- ROW_W, $clog2(ARRAY_SIZE): width of out_row (localparam).

- clk  in  1  clock, rising edge.
- srstn  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a tile; honoured only in IDLE.
- k_len  in  K_WIDTH  inner dimension K; sampled with start.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- accumulate  in  1  1 = keep accumulators from the previous tile, 0 = clear; sampled with start.
- a_valid  in  1  operand beat valid.
- in_ready  out  1  array accepts a beat.
- a_data  in  N·DATA_WIDTH  column k of A; element i (row i) at bits [i·DATA_WIDTH +: DATA_WIDTH].
- b_data  in  N·DATA_WIDTH  row k of B; element j (column j) at bits [j·DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts the row.
- out_row  out  ROW_W  index of the row being presented.
- out_data  out  N·ACC_WIDTH  C[out_row][j] at bits [j·ACC_WIDTH +: ACC_WIDTH].
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when the tile completes.

## Operation
- FSM states: IDLE, LOAD, DRAIN, READ.
  - IDLE→LOAD on start, when k_len ≠ 0.
  - IDLE→DRAIN on start, when k_len = 0.
  - LOAD→DRAIN after the K-th accepted beat.
  - DRAIN→READ after exactly 2N−1 drain cycles.
  - READ→IDLE after the handshake of row N−1.
- Beat accepted when in_ready && a_valid. in_ready = (state == LOAD).
- Step enable:
  - The skew registers, PE operand pipelines and accumulators advance only on an accepted beat or a DRAIN cycle.
  - A LOAD cycle without a_valid is a full array stall: no state change.
- Skew:
  - a_data row i passes through an input register plus i delay stages.
  - b_data column j passes through an input register plus j delay stages.
  - In DRAIN the skew inputs are fed zeros.
- PE(i,j), on each enabled step:
  - acc += a_in·b_in.
  - Forward a right and b down, registered.
  - Term k reaches PE(i,j) on step k+i+j+1.
- Arithmetic:
  - Product is 2·DATA_WIDTH bits, signed or unsigned per the latched signed_mode.
  - Product is sign- or zero-extended to ACC_WIDTH.
  - Sum wraps modulo 2^ACC_WIDTH; no saturation.
- Accumulate mode:
  - With accumulate = 0, all accumulators clear in the cycle start is accepted.
  - With accumulate = 1, accumulators keep their values.
  - Accumulators are never cleared by READ.
- READ:
  - Rows are presented in order 0..N−1; out_row advances on out_valid && out_ready.
  - out_data and out_row hold stable while out_valid && !out_ready.
- start while busy is ignored. k_len, signed_mode and accumulate are ignored outside the start cycle.

## Timing
- Reset values: state IDLE, all accumulators and pipeline/skew registers 0. in_ready, out_valid, busy, done = 0. out_row = 0, out_data = 0.
- srstn low clears everything immediately, including mid-LOAD/DRAIN/READ. The next tile with accumulate = 1 therefore starts from zero.
- Cycle numbering, with start sampled at cycle 0 and a_valid held high:
  - LOAD spans cycles 1..K.
  - DRAIN spans cycles K+1..K+2N−1.
  - out_valid rises at cycle K+2N.
- With out_ready held high, rows appear on consecutive cycles.
- done asserts the cycle after the row N−1 handshake, the same cycle busy falls. A new start is accepted in that cycle.
- Each a_valid gap adds exactly one cycle of latency. out_ready stalls add one cycle each.

## Test plan
- Identity, N=4, K=4, unsigned: A = I, B = 1..16 row-major → rows {1,2,3,4}…{13,14,15,16}. out_valid first seen at cycle 12, done pulses once.
- Signed vs unsigned, N=8, K=8, all operands 0x80/0xFF:
  - signed_mode=1 with 0x80 → every element 0x20000.
  - signed_mode=0 with 0xFF → every element 0x7F008.
- Accumulate: run the identity tile twice with accumulate=1 → every element doubled. Then run with accumulate=0 → single result.
- Backpressure: random a_valid gaps and out_ready deasserted for 3 cycles on row 2 → results identical to the no-stall run. out_data/out_row stable while stalled. Latency grows by exactly the stall count.
- Reset mid-LOAD: drop srstn after 2 beats → all outputs 0 immediately. A following tile with accumulate=1 yields only the new product.
- Edge cases:
  - ACC_WIDTH=16, unsigned, K=2, all 0xFF → every element 0xFC02 (wrap).
  - k_len=0 with accumulate=1 → READ after 2N−1 cycles returns the previous accumulators unchanged.

Source files
------------

// File: rtl/systolic_os_array_if.sv
// Operand-side and result-side handshake bundle of the output-stationary systolic array.
// The master is the fetch/writeback environment; the slave is the array itself.
interface systolic_os_array_if #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21,
    parameter int K_WIDTH    = 9
);
    localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    logic                             start;
    logic [K_WIDTH-1:0]               k_len;
    logic                             signed_mode;
    logic                             accumulate;
    logic                             a_valid;
    logic                             in_ready;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [ROW_W-1:0]                 out_row;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data;
    logic                             busy;
    logic                             done;

    modport master (
        output start, k_len, signed_mode, accumulate, a_valid, a_data, b_data, out_ready,
        input  in_ready, out_valid, out_row, out_data, busy, done
    );

    modport slave (
        input  start, k_len, signed_mode, accumulate, a_valid, a_data, b_data, out_ready,
        output in_ready, out_valid, out_row, out_data, busy, done
    );
endinterface

// File: rtl/systolic_os_array.sv
// Output-stationary N x N systolic matrix multiply: C (+)= A * B over a runtime K,
// with internal operand skew, signed/unsigned operands and row-by-row result readout.
module systolic_os_array #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21,
    parameter int K_WIDTH    = 9
) (
    input  logic                 clk,
    input  logic                 srstn,
    systolic_os_array_if.slave   bus
);
    localparam int N       = ARRAY_SIZE;
    localparam int DW      = DATA_WIDTH;
    localparam int PW2     = 2 * DATA_WIDTH + 2;
    localparam int ROW_W   = (N > 1) ? $clog2(N) : 1;
    localparam int DRAIN_W = $clog2(2 * N);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * N - 2);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [K_WIDTH-1:0]   r_beats_left;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [ROW_W-1:0]     r_row;
    logic                 r_signed;
    logic                 r_done;

    logic                 w_start_ok;
    logic                 w_beat;
    logic                 w_step;
    logic                 w_row_hs;
    logic                 w_clear;
    logic [N*DW-1:0]      w_a_feed;
    logic [N*DW-1:0]      w_b_feed;

    logic [DW-1:0]        w_a_in [N][N];
    logic [DW-1:0]        w_b_in [N][N];
    logic [ACC_WIDTH-1:0] w_acc  [N][N];

    // Operands are widened by one bit so a single signed multiplier serves both modes.
    function automatic logic [ACC_WIDTH-1:0] mac_term(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic          sgn
    );
        logic signed [PW2-1:0] ax;
        logic signed [PW2-1:0] bx;
        logic signed [PW2-1:0] p;
        ax = PW2'($signed({sgn & a[DW-1], a}));
        bx = PW2'($signed({sgn & b[DW-1], b}));
        p  = ax * bx;
        return ACC_WIDTH'(p);
    endfunction

    assign w_start_ok = (r_state == S_IDLE) && bus.start;
    assign w_beat     = (r_state == S_LOAD) && bus.a_valid;
    assign w_step     = w_beat || (r_state == S_DRAIN);
    assign w_row_hs   = (r_state == S_READ) && bus.out_ready;
    assign w_clear    = w_start_ok && !bus.accumulate;
    assign w_a_feed   = (r_state == S_DRAIN) ? '0 : bus.a_data;
    assign w_b_feed   = (r_state == S_DRAIN) ? '0 : bus.b_data;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = (bus.k_len != '0) ? S_LOAD : S_DRAIN;
            S_LOAD:  if (w_beat && (r_beats_left == K_WIDTH'(1))) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_READ;
            S_READ:  if (bus.out_ready && (r_row == ROW_LAST)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_LOAD);
        bus.out_valid = (r_state == S_READ);
        bus.busy      = (r_state != S_IDLE);
        bus.done      = r_done;
        bus.out_row   = r_row;
        bus.out_data  = '0;
        if (r_state == S_READ) begin
            for (int j = 0; j < N; j++) begin
                bus.out_data[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row][j];
            end
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_beats_left <= '0;
            r_drain_cnt  <= '0;
            r_row        <= '0;
            r_signed     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done      <= w_row_hs && (r_row == ROW_LAST);
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
            if (w_start_ok) begin
                r_beats_left <= bus.k_len;
                r_signed     <= bus.signed_mode;
            end else if (w_beat) begin
                r_beats_left <= r_beats_left - K_WIDTH'(1);
            end
            if (w_row_hs) begin
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end
        end
    end

    // Row g of A and column g of B each see an input register plus g delay stages.
    for (genvar g = 0; g < N; g++) begin : g_skew
        logic [DW-1:0] r_a_pipe [g+1];
        logic [DW-1:0] r_b_pipe [g+1];

        // NOTE: skew stages are ordinary registers, so they are cleared element by element on reset.
        always_ff @(posedge clk or negedge srstn) begin
            if (!srstn) begin
                for (int s = 0; s <= g; s++) begin
                    r_a_pipe[s] <= '0;
                    r_b_pipe[s] <= '0;
                end
            end else if (w_step) begin
                r_a_pipe[0] <= w_a_feed[g*DW +: DW];
                r_b_pipe[0] <= w_b_feed[g*DW +: DW];
                for (int s = 1; s <= g; s++) begin
                    r_a_pipe[s] <= r_a_pipe[s-1];
                    r_b_pipe[s] <= r_b_pipe[s-1];
                end
            end
        end

        assign w_a_in[g][0] = r_a_pipe[g];
        assign w_b_in[0][g] = r_b_pipe[g];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic [ACC_WIDTH-1:0] r_acc;

            always_ff @(posedge clk or negedge srstn) begin
                if (!srstn) begin
                    r_acc <= '0;
                end else if (w_clear) begin
                    r_acc <= '0;
                end else if (w_step) begin
                    r_acc <= r_acc + mac_term(w_a_in[i][j], w_b_in[i][j], r_signed);
                end
            end

            assign w_acc[i][j] = r_acc;

            // Edge PEs have no consumer to the right / below, so they keep no forward register.
            if (j < N - 1) begin : g_fwd_a
                logic [DW-1:0] r_a;
                always_ff @(posedge clk or negedge srstn) begin
                    if (!srstn) begin
                        r_a <= '0;
                    end else if (w_step) begin
                        r_a <= w_a_in[i][j];
                    end
                end
                assign w_a_in[i][j+1] = r_a;
            end

            if (i < N - 1) begin : g_fwd_b
                logic [DW-1:0] r_b;
                always_ff @(posedge clk or negedge srstn) begin
                    if (!srstn) begin
                        r_b <= '0;
                    end else if (w_step) begin
                        r_b <= w_b_in[i][j];
                    end
                end
                assign w_b_in[i+1][j] = r_b;
            end
        end
    end
endmodule

// File: tb/tb_systolic_os_array.sv
// Directed bench for systolic_os_array: a 21-bit and a 16-bit accumulator instance share
// stimulus and are checked every result cycle against a plain matrix-product model.
module tb_systolic_os_array;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 21;
    localparam int AW16 = 16;
    localparam int KW   = 9;
    localparam int KMAX = 8;

    logic clk   = 1'b0;
    logic srstn = 1'b0;
    always #5 clk = ~clk;

    systolic_os_array_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW),   .K_WIDTH(KW)) bus ();
    systolic_os_array_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW16), .K_WIDTH(KW)) bus16 ();

    assign bus16.start       = bus.start;
    assign bus16.k_len       = bus.k_len;
    assign bus16.signed_mode = bus.signed_mode;
    assign bus16.accumulate  = bus.accumulate;
    assign bus16.a_valid     = bus.a_valid;
    assign bus16.a_data      = bus.a_data;
    assign bus16.b_data      = bus.b_data;
    assign bus16.out_ready   = bus.out_ready;

    systolic_os_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) u_dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    systolic_os_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW16), .K_WIDTH(KW)) u_dut16 (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus16)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int c0    = 0;
    int first_valid_cyc = -1;
    bit seen_valid = 1'b0;
    bit exp_done   = 1'b0;
    bit stalled    = 1'b0;
    int exp_row    = 0;

    logic [N*AW-1:0]   held_data;
    logic [1:0]        held_row;
    logic [7:0]        a_mat [N][KMAX];
    logic [7:0]        b_mat [KMAX][N];
    int                gaps  [KMAX];
    longint            model_c [N][N];
    logic [N*AW-1:0]   cap     [N];
    logic [N*AW-1:0]   ref_cap [N];
    logic [N*AW16-1:0] cap16   [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint opv(input logic [7:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic logic [127:0] wrapv(input longint v, input int w);
        logic [127:0] m;
        m = (128'd1 << w) - 128'd1;
        return 128'(64'(v)) & m;
    endfunction

    function automatic logic [127:0] pack4(input int w, input int v0, input int v1,
                                           input int v2, input int v3);
        int v [4];
        logic [127:0] r;
        v = '{v0, v1, v2, v3};
        r = '0;
        for (int j = 0; j < 4; j++) r |= wrapv(longint'(v[j]), w) << (j * w);
        return r;
    endfunction

    // Compare process: every cycle, just after the falling edge.
    always begin
        @(negedge clk);
        #1;
        if (!srstn) begin
            exp_row  = 0;
            exp_done = 1'b0;
            stalled  = 1'b0;
        end else begin
            check("done", bus.done, exp_done);
            check("done16", bus16.done, exp_done);
            exp_done = 1'b0;
            check("valid16", bus16.out_valid, bus.out_valid);
            if (bus.out_valid) begin
                if (!seen_valid) begin
                    first_valid_cyc = cyc - c0;
                    seen_valid = 1'b1;
                end
                if (stalled) begin
                    check("hold_data", bus.out_data, held_data);
                    check("hold_row", bus.out_row, held_row);
                end
                check("out_row", bus.out_row, exp_row);
                check("out_row16", bus16.out_row, exp_row);
                for (int j = 0; j < N; j++) begin
                    check("c_main", bus.out_data[j*AW +: AW], wrapv(model_c[exp_row][j], AW));
                    check("c_acc16", bus16.out_data[j*AW16 +: AW16], wrapv(model_c[exp_row][j], AW16));
                end
                if (bus.out_ready) begin
                    cap[exp_row]   = bus.out_data;
                    cap16[exp_row] = bus16.out_data;
                    stalled = 1'b0;
                    if (exp_row == N - 1) begin
                        exp_row  = 0;
                        exp_done = 1'b1;
                    end else begin
                        exp_row++;
                    end
                end else begin
                    stalled   = 1'b1;
                    held_data = bus.out_data;
                    held_row  = bus.out_row;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic drive_idle();
        bus.start       = 1'b0;
        bus.k_len       = '0;
        bus.signed_mode = 1'b0;
        bus.accumulate  = 1'b0;
        bus.a_valid     = 1'b0;
        bus.a_data      = '0;
        bus.b_data      = '0;
        bus.out_ready   = 1'b1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) model_c[i][j] = 0;
    endtask

    task automatic model_tile(input int k, input bit sgn, input bit acc);
        if (!acc) clear_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int kk = 0; kk < k; kk++)
                    model_c[i][j] += opv(a_mat[i][kk], sgn) * opv(b_mat[kk][j], sgn);
    endtask

    task automatic set_identity();
        for (int kk = 0; kk < KMAX; kk++)
            for (int i = 0; i < N; i++) begin
                a_mat[i][kk] = (i == kk) ? 8'd1 : 8'd0;
                b_mat[kk][i] = 8'(4 * kk + i + 1);
            end
    endtask

    task automatic set_const(input logic [7:0] v);
        for (int kk = 0; kk < KMAX; kk++)
            for (int i = 0; i < N; i++) begin
                a_mat[i][kk] = v;
                b_mat[kk][i] = v;
            end
    endtask

    task automatic set_pattern();
        for (int kk = 0; kk < KMAX; kk++)
            for (int i = 0; i < N; i++) begin
                a_mat[i][kk] = 8'(i * 37 + kk * 11 + 5);
                b_mat[kk][i] = 8'(kk * 53 + i * 29 + 200);
            end
    endtask

    task automatic put_beat(input int kk);
        for (int i = 0; i < N; i++) begin
            bus.a_data[i*DW +: DW] = a_mat[i][kk];
            bus.b_data[i*DW +: DW] = b_mat[kk][i];
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"},  {bus16.in_ready,  bus.in_ready},  0);
        check({tag, "_out_valid"}, {bus16.out_valid, bus.out_valid}, 0);
        check({tag, "_busy"},      {bus16.busy,      bus.busy},      0);
        check({tag, "_done"},      {bus16.done,      bus.done},      0);
        check({tag, "_out_row"},   {bus16.out_row,   bus.out_row},   0);
        check({tag, "_out_data"},  bus.out_data,   0);
        check({tag, "_out_data16"}, bus16.out_data, 0);
    endtask

    // Called at a falling edge with the array idle; returns at the falling edge where done is seen.
    task automatic run_tile(input int k, input bit sgn, input bit acc, input int stall_n);
        int  gap_sum;
        int  stall_left;
        bit  got;
        model_tile(k, sgn, acc);
        seen_valid      = 1'b0;
        first_valid_cyc = -1;
        bus.start       = 1'b1;
        bus.k_len       = KW'(k);
        bus.signed_mode = sgn;
        bus.accumulate  = acc;
        @(negedge clk);
        c0              = cyc - 1;
        bus.start       = 1'b0;
        bus.k_len       = '1;
        bus.signed_mode = ~sgn;
        bus.accumulate  = ~acc;
        check("busy_run", bus.busy, 1);
        gap_sum = 0;
        for (int kk = 0; kk < k; kk++) begin
            for (int g = 0; g < gaps[kk]; g++) begin
                bus.a_valid = 1'b0;
                bus.a_data  = '1;
                check("in_ready_gap", bus.in_ready, 1);
                gap_sum++;
                @(negedge clk);
            end
            bus.a_valid = 1'b1;
            put_beat(kk);
            check("in_ready", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        bus.a_data  = '1;
        bus.b_data  = '1;
        stall_left  = stall_n;
        got         = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.out_valid && bus.out_row == 2'd2 && stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = 1'b1;
                end
                @(negedge clk);
            end
        end
        bus.out_ready = 1'b1;
        if (!got) begin
            check("done_timeout", 0, 1);
        end else begin
            check("first_valid_cycle", first_valid_cyc, k + 2 * N + gap_sum);
            check("done_cycle", cyc - c0, k + 3 * N + gap_sum + stall_n);
            check("busy_at_done", bus.busy, 0);
        end
    endtask

    task automatic apply_reset();
        srstn = 1'b0;
        #1;
        check_zero_outputs("reset");
        clear_model();
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        srstn = 1'b1;
    endtask

    initial begin
        drive_idle();
        clear_model();
        for (int kk = 0; kk < KMAX; kk++) gaps[kk] = 0;
        @(negedge clk);
        apply_reset();

        // Identity, accumulating from the reset-cleared state, then doubled, then cleared.
        set_identity();
        run_tile(4, 1'b0, 1'b1, 0);
        check("ident_lat", first_valid_cyc, 12);
        check("ident_row1", cap[1], pack4(AW, 5, 6, 7, 8));
        check("ident_row3", cap[3], pack4(AW, 13, 14, 15, 16));
        run_tile(4, 1'b0, 1'b1, 0);
        check("accum_row0", cap[0], pack4(AW, 2, 4, 6, 8));
        run_tile(4, 1'b0, 1'b0, 0);
        check("clear_row2", cap[2], pack4(AW, 9, 10, 11, 12));

        // Extreme operands, signed and unsigned.
        set_const(8'h80);
        run_tile(8, 1'b1, 1'b0, 0);
        check("signed_80", cap[0], pack4(AW, 'h20000, 'h20000, 'h20000, 'h20000));
        check("signed_80_w16", cap16[3], pack4(AW16, 0, 0, 0, 0));
        set_const(8'hFF);
        run_tile(8, 1'b0, 1'b0, 0);
        check("unsigned_ff", cap[1], pack4(AW, 'h7F008, 'h7F008, 'h7F008, 'h7F008));
        check("unsigned_ff_w16", cap16[1], pack4(AW16, 'hF008, 'hF008, 'hF008, 'hF008));

        // 16-bit wrap, then k_len = 0 returns the accumulators untouched.
        run_tile(2, 1'b0, 1'b0, 0);
        check("wrap16", cap16[0], pack4(AW16, 'hFC02, 'hFC02, 'hFC02, 'hFC02));
        check("wrap21", cap[0], pack4(AW, 'h1FC02, 'h1FC02, 'h1FC02, 'h1FC02));
        run_tile(0, 1'b0, 1'b1, 0);
        check("k0_keep", cap[3], pack4(AW, 'h1FC02, 'h1FC02, 'h1FC02, 'h1FC02));
        check("k0_keep16", cap16[2], pack4(AW16, 'hFC02, 'hFC02, 'hFC02, 'hFC02));

        // Backpressure: same signed tile with input gaps and a 3-cycle stall on row 2.
        set_pattern();
        run_tile(5, 1'b1, 1'b0, 0);
        for (int r = 0; r < N; r++) ref_cap[r] = cap[r];
        gaps[0] = 1;
        gaps[2] = 2;
        gaps[4] = 1;
        run_tile(5, 1'b1, 1'b0, 3);
        for (int r = 0; r < N; r++) check("stall_same", cap[r], ref_cap[r]);
        for (int kk = 0; kk < KMAX; kk++) gaps[kk] = 0;

        // Reset after two accepted beats, then an accumulate tile must start from zero.
        bus.start       = 1'b1;
        bus.k_len       = KW'(4);
        bus.signed_mode = 1'b0;
        bus.accumulate  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int kk = 0; kk < 3; kk++) begin
            bus.a_valid = 1'b1;
            put_beat(kk);
            if (kk < 2) @(negedge clk);
        end
        #2;
        apply_reset();
        set_identity();
        run_tile(4, 1'b0, 1'b1, 0);
        check("post_reset_row2", cap[2], pack4(AW, 9, 10, 11, 12));

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
